kr580_pic: RTL and testbench
============================

Name: kr580_pic

Overview:
- Port-mapped 8-input priority interrupt controller; the responder side of the kr580 CPU's I/O-port bus (pw/pr strobes) and the source of its intr input.
- Samples asynchronous IRQ lines, latches pending requests, applies a mask and in-service tracking, and drives intr.
- Hands the CPU an RST opcode through a vector-read port, and accepts EOI through a port write.
- Sits beside kr580 in the system top.

Parameters:
- BASE_PORT, 8'h10, port number of register 0; registers occupy BASE_PORT..BASE_PORT+2.
- SYNC_STAGES, 2, synchroniser depth per IRQ line, minimum 2.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- port_addr  in  8  I/O port number from CPU.
- port_wdata  in  8  CPU write data.
- pw  in  1  port write strobe.
- pr  in  1  port read strobe.
- port_rdata  out  8  registered read data to CPU.
- irq  in  8  asynchronous request lines; bit 0 has highest priority.
- intr  out  1  registered interrupt request to CPU.

Behaviour:
- Reset values:
  - pending=0, in_service=0, mask=8'hFF (all masked).
  - intr=0, port_rdata=0, synchroniser and edge history=0.
- Register map, offset from BASE_PORT:
  - +0 read: VECTOR. Returns 8'hC7|(n<<3) for highest-priority unmasked pending line n. Side effect: pending[n] clears, in_service[n] sets. If none is eligible, returns 8'h00 (NOP) with no state change.
  - +0 write: EOI. Clears the lowest-numbered set in_service bit; data is ignored.
  - +1 read/write: MASK; 1 = masked.
  - +2 read: PENDING. +2 write: write-1-to-clear pending bits.
  - Reads of other ports in range return 8'h00. Out-of-range ports: no effect, and port_rdata is not updated.
- Strobe qualification:
  - Side effects occur only on the first clock where pr (or pw) is 1 after being 0 (rising-edge detect of the registered previous strobe).
  - port_rdata is loaded on that same clock and holds until the next qualified read.
  - Read latency: 1 clock.
  - pr and pw both high in the same cycle: the write is performed, the read is ignored.
- Request path:
  - irq[i] rising at input → synchroniser output after SYNC_STAGES clocks.
  - Rising edge of the synchronised signal sets pending[i] on the next clock.
  - intr is updated one clock later.
  - Total with SYNC_STAGES=2: pending on edge k+2, intr on edge k+3.
- Eligibility:
  - Line n is eligible when pending[n] & ~mask[n], and no in_service bit j<=n is set.
  - intr = registered OR of eligibility.
  - Masking a pending line drops intr the clock after the MASK write; the pending bit is retained.
- Simultaneous events:
  - A new edge on line n in the same clock as VECTOR-ack of n, or as W1C of n: pending[n] stays 1 (set wins).
  - EOI in the same clock as a new request: both apply.
- Priority is fixed; no rotation. Nesting is permitted: a higher-priority line can be acked while a lower one is in service.
- Reset asserted mid-transaction: all state returns to reset values on that clock, and a strobe still held high after reset deasserts does not trigger a side effect.

Optional Feature:
- KR580_PIC_LEVEL_EN.
- When defined: each line is level-sensitive. pending[i] = synchronised irq[i] every clock; the ack clears nothing in pending, but sets in_service; W1C has no effect.
- When undefined: edge-triggered as specified above.

Decomposition:
- Package kr580_pic_pkg:
  - Register offsets: OFS_VECTOR=0, OFS_MASK=1, OFS_PEND=2.
  - RST_OPCODE_BASE=8'hC7, NOP_OPCODE=8'h00, NUM_IRQ=8.
- Sub-module kr580_pic_prio: purely combinational 8-bit lowest-index priority encoder with valid flag.
  - Instantiated twice: once for the eligible vector, once for the EOI in-service selection.

Test Plan:
- Reset values: assert reset for 3 clocks → intr=0; MASK read returns 8'hFF; PENDING read returns 8'h00.
- Single line: write MASK=8'hFB, pulse irq[2] → intr=1 three clocks after the edge; VECTOR read → port_rdata=8'hD7 one clock later; pending=0, intr=0; EOI write → in_service=0.
- Priority and nesting: irq[5] and irq[1] pending, mask=0 → VECTOR returns 8'hCF; after EOI, next VECTOR returns 8'hEF.
- Empty read: nothing pending → VECTOR returns 8'h00, and all state is unchanged.
- Simultaneous set/clear: W1C of bit 3 on the same clock pending[3] is newly set → pending[3]=1 afterward.
- Masking: pending line 4 with intr=1, write MASK=8'h10 → intr=0 next clock, PENDING=8'h10; unmask → intr=1 again.

Source files
------------

// File: rtl/kr580_pic_pkg.sv
// Shared constants and helpers for the kr580 port-mapped priority interrupt controller.
package kr580_pic_pkg;

  localparam int         NUM_IRQ         = 8;
  localparam logic [1:0] OFS_VECTOR      = 2'd0;
  localparam logic [1:0] OFS_MASK        = 2'd1;
  localparam logic [1:0] OFS_PEND        = 2'd2;
  localparam logic [7:0] RST_OPCODE_BASE = 8'hC7;
  localparam logic [7:0] NOP_OPCODE      = 8'h00;

  function automatic logic [7:0] rst_opcode(input logic [2:0] n);
    return RST_OPCODE_BASE | {2'b00, n, 3'b000};
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] n);
    return 8'd1 << n;
  endfunction

  // Bit i is set when any bit 0..i of v is set (in-service blocking mask).
  function automatic logic [7:0] prefix_or(input logic [7:0] v);
    logic [7:0] r;
    r[0] = v[0];
    for (int i = 1; i < NUM_IRQ; i++) begin
      r[i] = r[i-1] | v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/kr580_pic_prio.sv
// Combinational 8-bit priority encoder: lowest set index wins, valid when any bit set.
module kr580_pic_prio
  import kr580_pic_pkg::*;
(
  input  logic [7:0] i_req,
  output logic [2:0] o_idx,
  output logic       o_valid
);

  // Fixed priority, bit 0 highest.
  always_comb begin
    o_idx   = 3'd0;
    o_valid = 1'b1;
    casez (i_req)
      8'b???????1: o_idx = 3'd0;
      8'b??????10: o_idx = 3'd1;
      8'b?????100: o_idx = 3'd2;
      8'b????1000: o_idx = 3'd3;
      8'b???10000: o_idx = 3'd4;
      8'b??100000: o_idx = 3'd5;
      8'b?1000000: o_idx = 3'd6;
      8'b10000000: o_idx = 3'd7;
      default: begin
        o_idx   = 3'd0;
        o_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/kr580_pic.sv
// kr580 8-line priority interrupt controller on the CPU I/O-port bus.
// Define KR580_PIC_LEVEL_EN for level-sensitive request lines (default: edge-triggered).
module kr580_pic
  import kr580_pic_pkg::*;
#(
  parameter logic [7:0] BASE_PORT   = 8'h10,
  parameter int         SYNC_STAGES = 2
)(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] port_addr,
  input  logic [7:0] port_wdata,
  input  logic       pw,
  input  logic       pr,
  output logic [7:0] port_rdata,
  input  logic [7:0] irq,
  output logic       intr
);

  logic [7:0] r_sync [SYNC_STAGES];
  logic [7:0] r_pend, r_isr, r_mask, r_rdata;
  logic       r_intr, r_pr_prev, r_pw_prev;

  logic [7:0] w_ofs, w_elig, w_rdata_nxt, w_pend_nxt, w_isr_nxt;
  logic       w_in_range, w_rd_go, w_wr_go;
  logic       w_ack, w_eoi, w_mask_wr, w_w1c;
  logic [2:0] w_vec_idx, w_eoi_idx;
  logic       w_vec_valid, w_eoi_valid;

  assign port_rdata = r_rdata;
  assign intr       = r_intr;

  kr580_pic_prio u_prio_vec (.i_req(w_elig), .o_idx(w_vec_idx), .o_valid(w_vec_valid));
  kr580_pic_prio u_prio_eoi (.i_req(r_isr),  .o_idx(w_eoi_idx), .o_valid(w_eoi_valid));

  // Address decode and strobe qualification; a simultaneous write suppresses the read.
  always_comb begin
    w_ofs      = port_addr - BASE_PORT;
    w_in_range = (w_ofs < 8'd3);
    w_rd_go    = pr & ~r_pr_prev & ~pw & w_in_range;
    w_wr_go    = pw & ~r_pw_prev & w_in_range;
    w_ack      = w_rd_go & (w_ofs[1:0] == OFS_VECTOR) & w_vec_valid;
    w_eoi      = w_wr_go & (w_ofs[1:0] == OFS_VECTOR) & w_eoi_valid;
    w_mask_wr  = w_wr_go & (w_ofs[1:0] == OFS_MASK);
    w_w1c      = w_wr_go & (w_ofs[1:0] == OFS_PEND);
    w_elig     = r_pend & ~r_mask & ~prefix_or(r_isr);
  end

  // Read data mux.
  always_comb begin
    w_rdata_nxt = NOP_OPCODE;
    case (w_ofs[1:0])
      OFS_VECTOR: w_rdata_nxt = w_vec_valid ? rst_opcode(w_vec_idx) : NOP_OPCODE;
      OFS_MASK:   w_rdata_nxt = r_mask;
      OFS_PEND:   w_rdata_nxt = r_pend;
      default:    w_rdata_nxt = NOP_OPCODE;
    endcase
  end

  // In-service update: ack sets, EOI clears the lowest in-service line.
  always_comb begin
    w_isr_nxt = (r_isr & ~(w_eoi ? onehot8(w_eoi_idx) : 8'h00))
              | (w_ack ? onehot8(w_vec_idx) : 8'h00);
  end

`ifdef KR580_PIC_LEVEL_EN
  // Level mode: pending mirrors the synchronised lines; W1C is inert.
  always_comb begin
    w_pend_nxt = r_sync[SYNC_STAGES-1];
  end
`else
  logic [7:0] r_irq_prev;
  logic [7:0] w_edge;

  // Edge mode: a new edge always wins over a same-clock ack or W1C.
  always_comb begin
    w_edge     = r_sync[SYNC_STAGES-1] & ~r_irq_prev;
    w_pend_nxt = (r_pend & ~((w_ack ? onehot8(w_vec_idx) : 8'h00)
                           | (w_w1c ? port_wdata : 8'h00)))
               | w_edge;
  end

  // Edge history of the synchronised request lines.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_irq_prev <= 8'h00;
    end else begin
      r_irq_prev <= r_sync[SYNC_STAGES-1];
    end
  end
`endif

  // Strobe history keeps tracking during reset so a held strobe cannot fire afterwards.
  always_ff @(posedge clock) begin
    r_pr_prev <= pr;
    r_pw_prev <= pw;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= 8'h00;
      end
      r_pend  <= 8'h00;
      r_isr   <= 8'h00;
      r_mask  <= 8'hFF;
      r_rdata <= 8'h00;
      r_intr  <= 1'b0;
    end else begin
      r_sync[0] <= irq;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_pend <= w_pend_nxt;
      r_isr  <= w_isr_nxt;
      r_intr <= |w_elig;
      if (w_mask_wr) begin
        r_mask <= port_wdata;
      end
      if (w_rd_go) begin
        r_rdata <= w_rdata_nxt;
      end
    end
  end

endmodule

// File: tb/tb_kr580_pic.sv
// Self-checking bench for kr580_pic (default edge-triggered build): vector table plus timing sequences.
module tb_kr580_pic;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_addr = 8'h00;
  logic [7:0] port_wdata = 8'h00;
  logic       pw = 1'b0;
  logic       pr = 1'b0;
  logic [7:0] port_rdata;
  logic [7:0] irq = 8'h00;
  logic       intr;

  int n_pass  = 0;
  int n_total = 0;

  localparam int OP_RD   = 0;  // read port, compare data
  localparam int OP_WR   = 1;  // write port
  localparam int OP_IRQ  = 2;  // drive irq lines, let them propagate
  localparam int OP_INTR = 3;  // compare intr

  typedef struct {
    int         op;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  kr580_pic #(.BASE_PORT(8'h10), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .port_addr(port_addr), .port_wdata(port_wdata),
    .pw(pw), .pr(pr), .port_rdata(port_rdata), .irq(irq), .intr(intr)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    port_addr = a;
    pr = 1'b1;
    tick();
    d = port_rdata;
    pr = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_addr  = a;
    port_wdata = d;
    pw = 1'b1;
    tick();
    pw = 1'b0;
    tick();
  endtask

  task automatic add(input int op, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] e, input string n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  initial begin
    logic [7:0] d;

    // Reset state, out-of-range behaviour.
    add(OP_RD,   8'h11, 8'h00, 8'hFF, "rst_mask");
    add(OP_RD,   8'h13, 8'h00, 8'hFF, "oor_hi_hold");
    add(OP_RD,   8'h0F, 8'h00, 8'hFF, "oor_lo_hold");
    add(OP_RD,   8'h12, 8'h00, 8'h00, "rst_pend");
    add(OP_INTR, 8'h00, 8'h00, 8'h00, "rst_intr");
    add(OP_RD,   8'h10, 8'h00, 8'h00, "rst_vec_nop");
    add(OP_WR,   8'h13, 8'h00, 8'h00, "");
    add(OP_RD,   8'h11, 8'h00, 8'hFF, "oor_wr_nochg");
    // Single line 2.
    add(OP_WR,   8'h11, 8'hFB, 8'h00, "");
    add(OP_RD,   8'h11, 8'h00, 8'hFB, "mask_fb");
    add(OP_IRQ,  8'h00, 8'h04, 8'h00, "");
    add(OP_INTR, 8'h00, 8'h00, 8'h01, "intr_irq2");
    add(OP_RD,   8'h12, 8'h00, 8'h04, "pend_irq2");
    add(OP_RD,   8'h10, 8'h00, 8'hD7, "vec_irq2");
    add(OP_RD,   8'h12, 8'h00, 8'h00, "pend_after_ack");
    add(OP_INTR, 8'h00, 8'h00, 8'h00, "intr_after_ack");
    add(OP_WR,   8'h10, 8'h00, 8'h00, "");
    add(OP_IRQ,  8'h00, 8'h00, 8'h00, "");
    // Priority: lines 5 and 1.
    add(OP_WR,   8'h11, 8'h00, 8'h00, "");
    add(OP_IRQ,  8'h00, 8'h22, 8'h00, "");
    add(OP_INTR, 8'h00, 8'h00, 8'h01, "intr_1_5");
    add(OP_RD,   8'h12, 8'h00, 8'h22, "pend_1_5");
    add(OP_RD,   8'h10, 8'h00, 8'hCF, "vec_prio_1");
    add(OP_RD,   8'h10, 8'h00, 8'h00, "vec_blocked_5");
    add(OP_INTR, 8'h00, 8'h00, 8'h00, "intr_blocked");
    add(OP_WR,   8'h10, 8'h00, 8'h00, "");
    add(OP_INTR, 8'h00, 8'h00, 8'h01, "intr_after_eoi");
    add(OP_RD,   8'h10, 8'h00, 8'hEF, "vec_5");
    add(OP_INTR, 8'h00, 8'h00, 8'h00, "intr_5_acked");
    // Nesting: line 1 acked while line 5 is in service.
    add(OP_IRQ,  8'h00, 8'h20, 8'h00, "");
    add(OP_IRQ,  8'h00, 8'h22, 8'h00, "");
    add(OP_INTR, 8'h00, 8'h00, 8'h01, "intr_nest");
    add(OP_RD,   8'h10, 8'h00, 8'hCF, "vec_nest_1");
    add(OP_WR,   8'h10, 8'h00, 8'h00, "");
    add(OP_RD,   8'h10, 8'h00, 8'h00, "vec_nest_empty");
    add(OP_WR,   8'h10, 8'h00, 8'h00, "");
    add(OP_RD,   8'h12, 8'h00, 8'h00, "pend_nest_done");
    // Masking and W1C on line 4.
    add(OP_IRQ,  8'h00, 8'h00, 8'h00, "");
    add(OP_IRQ,  8'h00, 8'h10, 8'h00, "");
    add(OP_INTR, 8'h00, 8'h00, 8'h01, "intr_4");
    add(OP_WR,   8'h11, 8'h10, 8'h00, "");
    add(OP_INTR, 8'h00, 8'h00, 8'h00, "intr_masked_4");
    add(OP_RD,   8'h12, 8'h00, 8'h10, "pend_kept_4");
    add(OP_WR,   8'h11, 8'h00, 8'h00, "");
    add(OP_INTR, 8'h00, 8'h00, 8'h01, "intr_unmasked_4");
    add(OP_WR,   8'h12, 8'h10, 8'h00, "");
    add(OP_RD,   8'h12, 8'h00, 8'h00, "pend_w1c_4");
    add(OP_INTR, 8'h00, 8'h00, 8'h00, "intr_w1c_4");
    add(OP_RD,   8'h10, 8'h00, 8'h00, "vec_empty");
    add(OP_RD,   8'h11, 8'h00, 8'h00, "mask_unchanged");

    // Reset for 3 clocks.
    repeat (3) tick();
    chk("rst_intr_hold", {7'd0, intr}, 8'h00);
    chk("rst_rdata", port_rdata, 8'h00);
    reset = 1'b0;
    tick();

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_RD: begin
          rd(tbl[i].addr, d);
          chk(tbl[i].name, d, tbl[i].exp);
        end
        OP_WR:   wr(tbl[i].addr, tbl[i].data);
        OP_IRQ: begin
          irq = tbl[i].data;
          repeat (4) tick();
        end
        OP_INTR: chk(tbl[i].name, {7'd0, intr}, tbl[i].exp);
        default: chk("bad_op", 8'h01, 8'h00);
      endcase
    end

    // Request latency on line 3: intr rises exactly three edges after the sampling edge.
    irq = 8'h18;
    tick(); chk("lat_k0", {7'd0, intr}, 8'h00);
    tick(); chk("lat_k1", {7'd0, intr}, 8'h00);
    tick(); chk("lat_k2", {7'd0, intr}, 8'h00);
    tick(); chk("lat_k3", {7'd0, intr}, 8'h01);
    // MASK write drops intr on the following clock.
    port_addr = 8'h11; port_wdata = 8'h08; pw = 1'b1;
    tick(); chk("mask_e0", {7'd0, intr}, 8'h01);
    pw = 1'b0;
    tick(); chk("mask_e1", {7'd0, intr}, 8'h00);
    wr(8'h11, 8'h00);
    wr(8'h12, 8'h08);

    // W1C of line 3 on the same clock its new edge sets pending.
    irq = 8'h10;
    repeat (4) tick();
    irq = 8'h18;
    tick(); tick();
    port_addr = 8'h12; port_wdata = 8'h08; pw = 1'b1;
    tick();
    pw = 1'b0;
    tick();
    rd(8'h12, d); chk("w1c_vs_set", d, 8'h08);

    // VECTOR ack of line 3 on the same clock as a new edge on line 3.
    irq = 8'h10;
    repeat (4) tick();
    irq = 8'h18;
    tick(); tick();
    port_addr = 8'h10; pr = 1'b1;
    tick();
    chk("ack_vs_set_vec", port_rdata, 8'hDF);
    pr = 1'b0;
    tick();
    rd(8'h12, d); chk("ack_vs_set_pend", d, 8'h08);
    wr(8'h10, 8'h00);
    wr(8'h12, 8'h08);
    rd(8'h12, d); chk("pend_cleared_3", d, 8'h00);

    // Simultaneous pr and pw: write happens, read data register holds.
    wr(8'h11, 8'h5A);
    rd(8'h11, d); chk("mask_5a", d, 8'h5A);
    wr(8'h11, 8'hA5);
    port_addr = 8'h11; port_wdata = 8'h3C; pw = 1'b1; pr = 1'b1;
    tick();
    pw = 1'b0; pr = 1'b0;
    tick();
    chk("rw_read_ignored", port_rdata, 8'h5A);
    rd(8'h11, d); chk("rw_write_done", d, 8'h3C);

    // Reset mid-transaction with the write strobe held across reset release.
    irq = 8'h00;
    repeat (4) tick();
    port_addr = 8'h11; port_wdata = 8'h00; pw = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst2_rdata", port_rdata, 8'h00);
    tick(); tick();
    pw = 1'b0;
    tick();
    chk("rst2_intr", {7'd0, intr}, 8'h00);
    rd(8'h11, d); chk("rst2_strobe_held", d, 8'hFF);
    rd(8'h12, d); chk("rst2_pend", d, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
